// File: rtl/rx_block_assembler.sv
// Byte-stream framer: hunts for SYNC_BYTE, packs BLOCK_BYTES payload bytes into one word, holds it on valid/ready.
// Optional: define RX_BLOCK_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module rx_block_assembler #(
    parameter int unsigned BLOCK_BYTES    = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic [8*BLOCK_BYTES-1:0] block_data,
    output logic                     block_valid,
    input  logic                     block_ready,
    output logic                     frame_error,
    output logic                     overrun
);

    localparam int unsigned BLK_W = 8 * BLOCK_BYTES;
    localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_COLLECT   = 2'd1,
`ifdef RX_BLOCK_CHECKSUM_EN
        ST_CHECK     = 2'd2,
`endif
        ST_HOLD      = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [BLK_W-1:0] r_shift;
    logic [BLK_W-1:0] w_shift_next;
    logic             w_sync;
    logic             w_tmo_hit;
`ifdef RX_BLOCK_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    // Shift the new byte in at the LS end so the first payload byte ends up MS.
    if (BLOCK_BYTES == 1) begin : g_one
        assign w_shift_next = in_data;
    end else begin : g_many
        assign w_shift_next = {r_shift[BLK_W-9:0], in_data};
    end

    assign w_sync    = in_valid && (in_data == SYNC_BYTE);
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && !in_valid && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT_SYNC;
            r_byte_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_shift     <= '0;
            block_data  <= '0;
            block_valid <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef RX_BLOCK_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            case (r_state)
                ST_WAIT_SYNC: begin
                    if (w_sync) begin
                        r_state    <= ST_COLLECT;
                        r_byte_cnt <= '0;
                        r_tmo_cnt  <= '0;
                        r_shift    <= '0;
`ifdef RX_BLOCK_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        r_tmo_cnt  <= '0;
`ifdef RX_BLOCK_CHECKSUM_EN
                        r_csum     <= r_csum ^ in_data;
                        if (r_byte_cnt == LAST_CNT) begin
                            r_state <= ST_CHECK;
                        end
`else
                        if (r_byte_cnt == LAST_CNT) begin
                            r_state     <= ST_HOLD;
                            block_data  <= w_shift_next;
                            block_valid <= 1'b1;
                        end
`endif
                    end else if (w_tmo_hit) begin
                        frame_error <= 1'b1;
                        r_state     <= ST_WAIT_SYNC;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
`ifdef RX_BLOCK_CHECKSUM_EN
                ST_CHECK: begin
                    if (in_valid) begin
                        if (in_data == r_csum) begin
                            r_state     <= ST_HOLD;
                            block_data  <= r_shift;
                            block_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                            r_state     <= ST_WAIT_SYNC;
                        end
                    end else if (w_tmo_hit) begin
                        frame_error <= 1'b1;
                        r_state     <= ST_WAIT_SYNC;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
`endif
                ST_HOLD: begin
                    // A byte coinciding with the handshake is a sync candidate, not an overrun.
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        if (w_sync) begin
                            r_state    <= ST_COLLECT;
                            r_byte_cnt <= '0;
                            r_tmo_cnt  <= '0;
                            r_shift    <= '0;
`ifdef RX_BLOCK_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                        end else begin
                            r_state <= ST_WAIT_SYNC;
                        end
                    end else if (in_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: r_state <= ST_WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_block_assembler.sv
// Directed bench for rx_block_assembler: vector table plus hand sequences for timeout and reset.
module tb_rx_block_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [63:0] block_data;
    logic        block_valid;
    logic        block_ready;
    logic        frame_error;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        ev;
        logic [63:0] ed;
        logic        ef;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    rx_block_assembler #(
        .BLOCK_BYTES   (8),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .block_data (block_data),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then compare registered outputs just after the edge.
    task automatic apply_check(input logic v, input logic [7:0] d, input logic rdy, input logic r,
                               input logic ev, input logic [63:0] ed, input logic ef, input logic eo,
                               input string name);
        in_valid    = v;
        in_data     = d;
        block_ready = rdy;
        rst         = r;
        @(posedge clk);
        #1;
        n_vec++;
        if (block_valid !== ev || block_data !== ed || frame_error !== ef || overrun !== eo) begin
            n_err++;
            $display("FAIL %s: got valid=%b data=%h ferr=%b ovr=%b, want valid=%b data=%h ferr=%b ovr=%b",
                     name, block_valid, block_data, frame_error, overrun, ev, ed, ef, eo);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic rdy,
                       input logic ev, input logic [63:0] ed, input logic ef, input logic eo);
        vec_t x;
        x.v = v; x.d = d; x.rdy = rdy; x.ev = ev; x.ed = ed; x.ef = ef; x.eo = eo;
        tbl.push_back(x);
    endtask

    localparam logic [63:0] D1 = 64'h0102030405060708;
    localparam logic [63:0] D2 = 64'h11223344556677A5;
    localparam logic [63:0] D3 = 64'h2122232425262728;
    localparam logic [63:0] D4 = 64'h3132333435363738;
    localparam logic [63:0] D5 = 64'h5152535455565758;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        block_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        apply_check(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, "reset_state");

`ifndef RX_BLOCK_CHECKSUM_EN
        // Back-to-back frame with ready high: valid for exactly one cycle.
        add(1'b1, 8'hA5, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b1, 8'(k), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        add(1'b1, 8'h08, 1'b1, 1'b1, D1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, D1, 1'b0, 1'b0);
        // Leading junk, SYNC value as last payload byte, long hold.
        add(1'b1, 8'h00, 1'b0, 1'b0, D1, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, D1, 1'b0, 1'b0);
        add(1'b1, 8'hA5, 1'b0, 1'b0, D1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b1, 8'(k * 17), 1'b0, 1'b0, D1, 1'b0, 1'b0);
        add(1'b1, 8'hA5, 1'b0, 1'b1, D2, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) add(1'b0, 8'h00, 1'b0, 1'b1, D2, 1'b0, 1'b0);
        // Overrun while held, then sync byte coinciding with the handshake.
        add(1'b1, 8'h5A, 1'b0, 1'b1, D2, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, D2, 1'b0, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b0, D2, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b1, 8'(8'h20 + k), 1'b1, 1'b0, D2, 1'b0, 1'b0);
        add(1'b1, 8'h28, 1'b1, 1'b1, D3, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, D3, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++)
            apply_check(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0, tbl[i].ev, tbl[i].ed,
                        tbl[i].ef, tbl[i].eo, $sformatf("vec%0d", i));

        // Timeout: a 30-cycle gap is tolerated, a 50-cycle gap aborts exactly once.
        apply_check(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, D3, 1'b0, 1'b0, "tmo_sync");
        apply_check(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, D3, 1'b0, 1'b0, "tmo_b1");
        for (int i = 1; i <= 30; i++)
            apply_check(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, D3, 1'b0, 1'b0, $sformatf("tmo_gap%0d", i));
        apply_check(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, D3, 1'b0, 1'b0, "tmo_b2");
        for (int i = 1; i <= 60; i++)
            apply_check(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, D3, (i == 50), 1'b0, $sformatf("tmo_idle%0d", i));
        apply_check(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, D3, 1'b0, 1'b0, "post_tmo_sync");
        for (int k = 1; k < 8; k++)
            apply_check(1'b1, 8'(8'h30 + k), 1'b1, 1'b0, 1'b0, D3, 1'b0, 1'b0, "post_tmo_byte");
        apply_check(1'b1, 8'h38, 1'b1, 1'b0, 1'b1, D4, 1'b0, 1'b0, "post_tmo_block");
        apply_check(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, D4, 1'b0, 1'b0, "post_tmo_drop");

        // Reset mid-frame clears everything, then a fresh frame assembles cleanly.
        apply_check(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, D4, 1'b0, 1'b0, "rst_sync");
        for (int k = 1; k <= 4; k++)
            apply_check(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b0, D4, 1'b0, 1'b0, "rst_byte");
        apply_check(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, "rst_mid_frame");
        apply_check(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, "rst_no_resume");
        apply_check(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, "rst_new_sync");
        for (int k = 1; k < 8; k++)
            apply_check(1'b1, 8'(8'h50 + k), 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, "rst_new_byte");
        apply_check(1'b1, 8'h58, 1'b1, 1'b0, 1'b1, D5, 1'b0, 1'b0, "rst_new_block");
        apply_check(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, D5, 1'b0, 1'b0, "rst_new_drop");
`else
        // Good checksum (XOR of 01..08 is 08) delivers the block.
        add(1'b1, 8'hA5, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) add(1'b1, 8'(k), 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        add(1'b1, 8'h08, 1'b1, 1'b1, D1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, D1, 1'b0, 1'b0);
        // Bad checksum: frame_error pulse, no block.
        add(1'b1, 8'hA5, 1'b1, 1'b0, D1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) add(1'b1, 8'(k), 1'b1, 1'b0, D1, 1'b0, 1'b0);
        add(1'b1, 8'h09, 1'b1, 1'b0, D1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, D1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, D1, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++)
            apply_check(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0, tbl[i].ev, tbl[i].ed,
                        tbl[i].ef, tbl[i].eo, $sformatf("csum_vec%0d", i));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_block_assembler.md
Name: rx_block_assembler

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (data byte plus one-cycle valid pulse).
- Hunts for a sync byte, then packs the next BLOCK_BYTES bytes into one wide word for the Speck core.
- Presents the word on a valid/ready handshake and holds it until the consumer accepts it.
- Aborts partial frames on an inter-byte timeout and flags errors and overruns.

Parameters:
- BLOCK_BYTES, 8, payload bytes per block (8 gives a 64-bit Speck block); legal range 1..32.
- SYNC_BYTE, 8'hA5, frame header value.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles allowed between payload bytes before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  received byte from the UART receiver
- in_valid  in  1  one-cycle pulse; in_data is valid this cycle
- block_data  out  8*BLOCK_BYTES  assembled block; first payload byte in the MS byte
- block_valid  out  1  block available; held until accepted
- block_ready  in  1  consumer accepts block_data when block_valid && block_ready
- frame_error  out  1  one-cycle pulse on timeout abort (or checksum failure)
- overrun  out  1  one-cycle pulse when a byte arrives while in HOLD and is not consumed

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-frame and mid-HOLD):
  - state = WAIT_SYNC; byte_cnt = 0; timeout counter = 0.
  - block_data = 0; block_valid = 0; frame_error = 0; overrun = 0.
  - Any partial frame is discarded.
- WAIT_SYNC:
  - in_valid && in_data == SYNC_BYTE: go to COLLECT, byte_cnt = 0, clear the shift register.
  - Any other byte is discarded silently, with no flag.
- COLLECT:
  - On in_valid: shift register = {shift[8*BLOCK_BYTES-9:0], in_data}; byte_cnt += 1; timeout counter = 0.
  - A byte equal to SYNC_BYTE here is payload data, not a resync.
  - When the byte that completes BLOCK_BYTES arrives, the next state is HOLD. With CHECKSUM_EN defined, the next state is CHECK instead.
  - No in_valid: timeout counter += 1.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: pulse frame_error for 1 cycle, go to WAIT_SYNC, discard partial data.
- HOLD:
  - block_data = completed shift register; block_valid = 1, registered.
  - Latency: block_valid rises on the clk edge after the in_valid cycle of the last payload byte. With CHECKSUM_EN, the reference byte is the checksum byte.
  - block_data is stable while block_valid = 1.
  - block_ready = 1: block_valid drops next cycle; state returns to WAIT_SYNC.
  - in_valid while block_ready = 0: the byte is dropped and overrun pulses for 1 cycle. State, data and valid are unchanged.
  - in_valid in the same cycle as block_ready = 1: the handshake completes, the byte is not an overrun, and it is evaluated as a sync candidate. If it equals SYNC_BYTE, the next state is COLLECT directly.
- No timeout in WAIT_SYNC or HOLD.
- byte_cnt width: $clog2(BLOCK_BYTES+1). No wrap-around is possible, because the count resets on each sync.
- frame_error and overrun are never asserted in the same cycle by construction.

Optional Feature:
- Macro: RX_BLOCK_CHECKSUM_EN.
- Defined:
  - A CHECK state follows COLLECT and waits for one extra byte (the timeout still applies).
  - The expected checksum is the XOR of all BLOCK_BYTES payload bytes.
  - Match: go to HOLD.
  - Mismatch: pulse frame_error, discard the block, go to WAIT_SYNC.
- Undefined: no CHECK state, and no checksum byte is expected on the wire.

Test Plan:
- rst, then bytes A5 01 02 03 04 05 06 07 08 with block_ready = 1 -> block_data = 64'h0102030405060708; block_valid high for exactly 1 cycle, one cycle after byte 08.
- Bytes 00 FF A5 11 22 33 44 55 66 77 A5 with block_ready = 0 -> leading 00 FF are ignored; block_data = 64'h11223344556677A5; block_valid held ≥ 20 cycles until block_ready.
- While held, send byte 5A -> overrun pulses 1 cycle, block_data unchanged. Then block_ready = 1 in the same cycle as byte A5 -> handshake done, no overrun, next state COLLECT.
- TIMEOUT_CYCLES = 50: A5 01 02, then silence -> frame_error pulses once, 50 cycles after byte 02. Then A5 + 8 bytes -> a correct block with no residue of 01 02.
- Assert rst during COLLECT after 4 payload bytes -> all outputs 0 the next cycle. A new full frame after reset assembles correctly.
- RX_BLOCK_CHECKSUM_EN defined: A5 01..08 then 08 -> block delivered (XOR = 08). Same payload then 09 -> frame_error pulse, no block_valid.
